// File: rtl/multicycle_controller.sv
// Main control FSM of the multi-cycle MIPS datapath (IF/ID/EX/MEM/WB) with registered Moore outputs.
// Optional MULTICYCLE_ILLEGAL_TRAP_EN: illegal instructions park in TRAP and raise IllegalInst.
module multicycle_controller #(
  parameter int STATE_W = 4,
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         OpCode,
  input  logic [5:0]         Funct,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               ExtOp,
  output logic               LuiOp,
  output logic [1:0]         RegDst,
  output logic [1:0]         MemtoReg,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic [STATE_W-1:0] State
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic               IllegalInst
`endif
);

  typedef enum logic [STATE_W-1:0] {
    S_IF   = STATE_W'(0),  S_ID  = STATE_W'(1),  S_MADR = STATE_W'(2),
    S_MRD  = STATE_W'(3),  S_MWB = STATE_W'(4),  S_MWR  = STATE_W'(5),
    S_REX  = STATE_W'(6),  S_RWB = STATE_W'(7),  S_BEQ  = STATE_W'(8),
    S_JMP  = STATE_W'(9),  S_IEX = STATE_W'(10), S_IWB  = STATE_W'(11),
    S_TRAP = STATE_W'(12)
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       ext_op;
    logic       lui_op;
    logic [1:0] reg_dst;
    logic [1:0] memto_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic [3:0] alu_op;
  } ctrl_t;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  localparam state_t S_ILL = S_TRAP;
`else
  localparam state_t S_ILL = S_IF;
`endif

  state_t state_r;
  state_t nxt_state_s;
  ctrl_t  nxt_ctrl_s;
  logic   armed_r;

  function automatic logic is_legal_rtype(input logic [5:0] fn);
    case (fn)
      6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
      6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
      6'h2a, 6'h2b: is_legal_rtype = 1'b1;
      default:      is_legal_rtype = 1'b0;
    endcase
  endfunction

  // Control word presented while sitting in state st; EX/WB/JMP also look at the instruction.
  function automatic ctrl_t decode(input state_t st, input logic [5:0] op, input logic [5:0] fn);
    ctrl_t d;
    d = '0;
    case (st)
      S_IF:   begin d.mem_read = 1'b1; d.ir_write = 1'b1; d.pc_write = 1'b1; d.alu_src_b = 2'd1; end
      S_ID:   begin d.alu_src_b = 2'd3; d.ext_op = 1'b1; end
      S_MADR: begin d.alu_src_a = 2'd1; d.alu_src_b = 2'd2; d.ext_op = 1'b1; end
      S_MRD:  begin d.mem_read = 1'b1; d.iord = 1'b1; end
      S_MWB:  begin d.reg_write = 1'b1; d.memto_reg = 2'd1; end
      S_MWR:  begin d.mem_write = 1'b1; d.iord = 1'b1; end
      S_REX: begin
        if ((fn == 6'h00) || (fn == 6'h02) || (fn == 6'h03)) d.alu_src_a = 2'd2;
        else                                               d.alu_src_a = 2'd1;
        d.alu_op = 4'b0001;
      end
      S_RWB:  begin d.reg_write = 1'b1; d.reg_dst = 2'd1; end
      S_BEQ: begin
        d.alu_src_a = 2'd1; d.alu_op = 4'b0011; d.pc_write_cond = 1'b1; d.pc_source = 2'd1;
      end
      S_JMP: begin
        d.pc_write = 1'b1;
        if (op == 6'h00) begin
          d.pc_source = 2'd3;
          if (fn == 6'h09) begin d.reg_write = 1'b1; d.reg_dst = 2'd1; d.memto_reg = 2'd2; end
          else             d.reg_write = 1'b0;
        end else begin
          d.pc_source = 2'd2;
          if (op == 6'h03) begin d.reg_write = 1'b1; d.reg_dst = 2'd2; d.memto_reg = 2'd2; end
          else             d.reg_write = 1'b0;
        end
      end
      // IWB keeps the IEX ALU setup so the ALU output stays consistent while writing back.
      S_IEX, S_IWB: begin
        d.alu_src_a = 2'd1;
        d.alu_src_b = 2'd2;
        d.reg_write = (st == S_IWB);
        case (op)
          6'h08:   d.ext_op = 1'b1;
          6'h09:   begin d.alu_op = 4'b1000; d.ext_op = 1'b1; end
          6'h0a:   begin d.alu_op = 4'b0010; d.ext_op = 1'b1; end
          6'h0b:   begin d.alu_op = 4'b1010; d.ext_op = 1'b1; end
          6'h0c:   d.alu_op = 4'b1100;
          6'h0f:   d.lui_op = 1'b1;
          default: d.alu_op = 4'b0000;
        endcase
      end
      default: d = '0;
    endcase
    decode = d;
  endfunction

  // Next-state selection; the first IF after reset is a quiet cycle that arms fetch.
  always_comb begin
    nxt_state_s = S_IF;
    case (state_r)
      S_IF: begin
        if (armed_r) nxt_state_s = S_ID;
        else         nxt_state_s = S_IF;
      end
      S_ID: begin
        case (OpCode)
          6'h23, 6'h2b: nxt_state_s = S_MADR;
          6'h00: begin
            if ((Funct == 6'h08) || (Funct == 6'h09)) nxt_state_s = S_JMP;
            else if (is_legal_rtype(Funct))           nxt_state_s = S_REX;
            else                                      nxt_state_s = S_ILL;
          end
          6'h04:        nxt_state_s = S_BEQ;
          6'h02, 6'h03: nxt_state_s = S_JMP;
          6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: nxt_state_s = S_IEX;
          default:      nxt_state_s = S_ILL;
        endcase
      end
      S_MADR: begin
        if (OpCode == 6'h23) nxt_state_s = S_MRD;
        else                 nxt_state_s = S_MWR;
      end
      S_MRD: nxt_state_s = S_MWB;
      S_REX: nxt_state_s = S_RWB;
      S_IEX: nxt_state_s = S_IWB;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      S_TRAP: nxt_state_s = S_TRAP;
`endif
      default: nxt_state_s = S_IF;
    endcase
    nxt_ctrl_s = decode(nxt_state_s, OpCode, Funct);
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= S_IF;
      armed_r     <= 1'b0;
      PCWrite     <= 1'b0;
      PCWriteCond <= 1'b0;
      IorD        <= 1'b0;
      MemRead     <= 1'b0;
      MemWrite    <= 1'b0;
      IRWrite     <= 1'b0;
      RegWrite    <= 1'b0;
      ExtOp       <= 1'b0;
      LuiOp       <= 1'b0;
      RegDst      <= 2'd0;
      MemtoReg    <= 2'd0;
      ALUSrcA     <= 2'd0;
      ALUSrcB     <= 2'd0;
      PCSource    <= 2'd0;
      ALUOp       <= '0;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      IllegalInst <= 1'b0;
`endif
    end else begin
      state_r     <= nxt_state_s;
      armed_r     <= 1'b1;
      PCWrite     <= nxt_ctrl_s.pc_write;
      PCWriteCond <= nxt_ctrl_s.pc_write_cond;
      IorD        <= nxt_ctrl_s.iord;
      MemRead     <= nxt_ctrl_s.mem_read;
      MemWrite    <= nxt_ctrl_s.mem_write;
      IRWrite     <= nxt_ctrl_s.ir_write;
      RegWrite    <= nxt_ctrl_s.reg_write;
      ExtOp       <= nxt_ctrl_s.ext_op;
      LuiOp       <= nxt_ctrl_s.lui_op;
      RegDst      <= nxt_ctrl_s.reg_dst;
      MemtoReg    <= nxt_ctrl_s.memto_reg;
      ALUSrcA     <= nxt_ctrl_s.alu_src_a;
      ALUSrcB     <= nxt_ctrl_s.alu_src_b;
      PCSource    <= nxt_ctrl_s.pc_source;
      ALUOp       <= ALUOP_W'(nxt_ctrl_s.alu_op);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      IllegalInst <= (nxt_state_s == S_TRAP);
`endif
    end
  end

  assign State = state_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller: per-instruction state walks and control words.
module tb_multicycle_controller;

  logic       clk, reset;
  logic [5:0] OpCode, Funct;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ExtOp, LuiOp;
  logic [1:0] RegDst, MemtoReg, ALUSrcA, ALUSrcB, PCSource;
  logic [3:0] ALUOp;
  logic [3:0] State;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       IllegalInst;
`endif

  int errors = 0;
  int checks = 0;

  multicycle_controller #(.STATE_W(4), .ALUOP_W(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
    .PCSource(PCSource), .ALUOp(ALUOp), .State(State)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , .IllegalInst(IllegalInst)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; OpCode = 6'h00; Funct = 6'h00;
    repeat (2) step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL rst_state got=%0d exp=0", State); end
    checks++; if (IRWrite !== 1'b0) begin errors++; $display("FAIL rst_irwrite got=%0b exp=0", IRWrite); end
    checks++; if ({PCWrite, MemRead, ALUSrcB} !== 4'b0000) begin errors++; $display("FAIL rst_outputs got=%b exp=0000", {PCWrite, MemRead, ALUSrcB}); end
    @(negedge clk); reset = 1'b1; #1;
    checks++; if (MemRead !== 1'b0) begin errors++; $display("FAIL rel_memread got=%0b exp=0", MemRead); end
    step();
    checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL first_if_irwrite got=%0b exp=1", IRWrite); end
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL first_if_state got=%0d exp=0", State); end
    checks++; if ({PCWrite, MemRead, IorD, ALUSrcA, ALUSrcB, PCSource, ALUOp} !== 13'b1_1_0_00_01_00_0000) begin
      errors++; $display("FAIL if_ctrl got=%b exp=1100001000000", {PCWrite, MemRead, IorD, ALUSrcA, ALUSrcB, PCSource, ALUOp}); end
  endtask

  task automatic test_lw();
    int reads;
    int exp_st[5] = '{1, 2, 3, 4, 0};
    reads = 0;
    OpCode = 6'h23; Funct = 6'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++; if (State !== exp_st[i][3:0]) begin errors++; $display("FAIL lw_state[%0d] got=%0d exp=%0d", i, State, exp_st[i]); end
      if (i < 4 && MemRead === 1'b1) reads++;
      if (i == 0) begin
        checks++; if ({ALUSrcA, ALUSrcB, ExtOp} !== 5'b00_11_1) begin errors++; $display("FAIL id_ctrl got=%b exp=00111", {ALUSrcA, ALUSrcB, ExtOp}); end
      end else if (i == 1) begin
        checks++; if ({ALUSrcA, ALUSrcB, ExtOp, ALUOp} !== 9'b01_10_1_0000) begin errors++; $display("FAIL madr_ctrl got=%b exp=011010000", {ALUSrcA, ALUSrcB, ExtOp, ALUOp}); end
      end else if (i == 2) begin
        checks++; if ({MemRead, IorD, RegWrite} !== 3'b110) begin errors++; $display("FAIL mrd_ctrl got=%b exp=110", {MemRead, IorD, RegWrite}); end
      end else if (i == 3) begin
        checks++; if ({RegWrite, MemtoReg, RegDst} !== 5'b1_01_00) begin errors++; $display("FAIL mwb_ctrl got=%b exp=10100", {RegWrite, MemtoReg, RegDst}); end
      end else begin
        checks++; if (IRWrite !== 1'b1) begin errors++; $display("FAIL lw_next_if got=%0b exp=1", IRWrite); end
      end
    end
    checks++; if (reads !== 1) begin errors++; $display("FAIL lw_memread_count got=%0d exp=1", reads); end
  endtask

  task automatic test_sw();
    OpCode = 6'h2b;
    step(); step(); step();
    checks++; if (State !== 4'd5) begin errors++; $display("FAIL sw_state got=%0d exp=5", State); end
    checks++; if ({MemWrite, IorD, MemRead, RegWrite} !== 4'b1100) begin errors++; $display("FAIL mwr_ctrl got=%b exp=1100", {MemWrite, IorD, MemRead, RegWrite}); end
    step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL sw_end got=%0d exp=0", State); end
  endtask

  task automatic test_rtype();
    logic [5:0] fn[2] = '{6'h03, 6'h2b};
    logic [1:0] srca[2] = '{2'd2, 2'd1};
    OpCode = 6'h00;
    for (int i = 0; i < 2; i++) begin
      Funct = fn[i];
      step(); step();
      checks++; if (State !== 4'd6) begin errors++; $display("FAIL rex_state[%0d] got=%0d exp=6", i, State); end
      checks++; if ({ALUSrcA, ALUSrcB, ALUOp} !== {srca[i], 2'd0, 4'b0001}) begin errors++; $display("FAIL rex_ctrl[%0d] got=%b exp=%b", i, {ALUSrcA, ALUSrcB, ALUOp}, {srca[i], 2'd0, 4'b0001}); end
      step();
      checks++; if ({State, RegWrite, RegDst, MemtoReg} !== 9'b0111_1_01_00) begin errors++; $display("FAIL rwb_ctrl[%0d] got=%b exp=011110100", i, {State, RegWrite, RegDst, MemtoReg}); end
      step();
      checks++; if (State !== 4'd0) begin errors++; $display("FAIL r_end[%0d] got=%0d exp=0", i, State); end
    end
  endtask

  task automatic test_itype();
    logic [5:0] op[3] = '{6'h0b, 6'h0c, 6'h0f};
    logic [3:0] aop[3] = '{4'b1010, 4'b1100, 4'b0000};
    logic       ext[3] = '{1'b1, 1'b0, 1'b0};
    logic       lui[3] = '{1'b0, 1'b0, 1'b1};
    Funct = 6'h00;
    for (int i = 0; i < 3; i++) begin
      OpCode = op[i];
      step(); step();
      checks++; if ({State, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuiOp, RegWrite} !== {4'd10, 2'd1, 2'd2, aop[i], ext[i], lui[i], 1'b0}) begin
        errors++; $display("FAIL iex_ctrl[%0d] got=%b exp=%b", i, {State, ALUSrcA, ALUSrcB, ALUOp, ExtOp, LuiOp, RegWrite}, {4'd10, 2'd1, 2'd2, aop[i], ext[i], lui[i], 1'b0}); end
      step();
      checks++; if ({State, RegWrite, RegDst, MemtoReg, ALUOp} !== {4'd11, 1'b1, 2'd0, 2'd0, aop[i]}) begin
        errors++; $display("FAIL iwb_ctrl[%0d] got=%b exp=%b", i, {State, RegWrite, RegDst, MemtoReg, ALUOp}, {4'd11, 1'b1, 2'd0, 2'd0, aop[i]}); end
      step();
      checks++; if (State !== 4'd0) begin errors++; $display("FAIL i_end[%0d] got=%0d exp=0", i, State); end
    end
  endtask

  task automatic test_branch_jump();
    OpCode = 6'h04; Funct = 6'h00;
    step(); step();
    checks++; if ({State, PCWriteCond, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp} !== {4'd8, 1'b1, 1'b0, 2'd1, 2'd1, 2'd0, 4'b0011}) begin
      errors++; $display("FAIL beq_ctrl got=%b", {State, PCWriteCond, PCWrite, PCSource, ALUSrcA, ALUSrcB, ALUOp}); end
    step();
    OpCode = 6'h03;
    step(); step();
    checks++; if ({State, PCWrite, PCSource, RegWrite, RegDst, MemtoReg} !== {4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2}) begin
      errors++; $display("FAIL jal_ctrl got=%b exp=%b", {State, PCWrite, PCSource, RegWrite, RegDst, MemtoReg}, {4'd9, 1'b1, 2'd2, 1'b1, 2'd2, 2'd2}); end
    step();
    OpCode = 6'h00; Funct = 6'h08;
    step(); step();
    checks++; if ({State, PCWrite, PCSource, RegWrite} !== {4'd9, 1'b1, 2'd3, 1'b0}) begin
      errors++; $display("FAIL jr_ctrl got=%b exp=%b", {State, PCWrite, PCSource, RegWrite}, {4'd9, 1'b1, 2'd3, 1'b0}); end
    step();
    Funct = 6'h09;
    step(); step();
    checks++; if ({PCSource, RegWrite, RegDst, MemtoReg} !== {2'd3, 1'b1, 2'd1, 2'd2}) begin
      errors++; $display("FAIL jalr_ctrl got=%b exp=%b", {PCSource, RegWrite, RegDst, MemtoReg}, {2'd3, 1'b1, 2'd1, 2'd2}); end
    step();
    checks++; if (State !== 4'd0) begin errors++; $display("FAIL jalr_end got=%0d exp=0", State); end
  endtask

  task automatic test_reset_mid_mrd();
    OpCode = 6'h23; Funct = 6'h00;
    step(); step(); step();
    checks++; if (State !== 4'd3) begin errors++; $display("FAIL mid_pre_state got=%0d exp=3", State); end
    reset = 1'b0; #1;
    checks++; if ({State, MemRead} !== 5'b0000_0) begin errors++; $display("FAIL mid_async got=%b exp=00000", {State, MemRead}); end
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b1; #1;
    checks++; if ({State, MemRead, RegWrite} !== 6'b0000_00) begin errors++; $display("FAIL mid_release got=%b exp=000000", {State, MemRead, RegWrite}); end
    step();
    checks++; if ({State, IRWrite} !== 5'b0000_1) begin errors++; $display("FAIL mid_refetch got=%b exp=00001", {State, IRWrite}); end
  endtask

  task automatic test_illegal();
    OpCode = 6'h3f; Funct = 6'h00;
    step();
    checks++; if ({State, RegWrite, MemWrite} !== {4'd1, 1'b0, 1'b0}) begin errors++; $display("FAIL ill_id got=%b", {State, RegWrite, MemWrite}); end
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    for (int i = 0; i < 10; i++) begin
      step();
      checks++; if ({State, IllegalInst, PCWrite, RegWrite, MemWrite, IRWrite} !== {4'd12, 1'b1, 4'b0000}) begin
        errors++; $display("FAIL trap_hold[%0d] got=%b exp=110010000", i, {State, IllegalInst, PCWrite, RegWrite, MemWrite, IRWrite}); end
    end
    reset = 1'b0; #1;
    checks++; if ({State, IllegalInst} !== 5'b0000_0) begin errors++; $display("FAIL trap_reset got=%b exp=00000", {State, IllegalInst}); end
    @(negedge clk); reset = 1'b1;
    step();
`else
    step();
    checks++; if ({State, IRWrite, RegWrite, MemWrite} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ill_to_if got=%b exp=0000100", {State, IRWrite, RegWrite, MemWrite}); end
    OpCode = 6'h00; Funct = 6'h3f;
    step(); step();
    checks++; if ({State, RegWrite, MemWrite} !== {4'd0, 1'b0, 1'b0}) begin
      errors++; $display("FAIL ill_funct got=%b exp=000000", {State, RegWrite, MemWrite}); end
`endif
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw();
    test_rtype();
    test_itype();
    test_branch_jump();
    test_reset_mid_mrd();
    test_illegal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
